uart_tx: RTL and testbench

Transmit-side UART engine. It accepts a parallel word through a valid/busy handshake and serialises it onto a single line as start bit, WIDTH data bits (LSB first), an optional parity bit, then one stop bit. Each bit is held for CLKS_PER_BIT clock cycles. The block is the counterpart of the RX path: its bit order and parity conventions match what the receiver's deserializer and parity checker expect.

---
 rtl/uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Transmit-side UART engine: start bit, WIDTH data bits LSB first, optional
// even/odd parity bit, one stop bit; every bit held for CLKS_PER_BIT clocks.
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_data,
    input  logic             data_valid,
    input  logic             par_en,
    input  logic             par_typ,
    output logic             tx_out,
    output logic             busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity is the XOR of the word; odd parity inverts it.
    function automatic logic parity_bit(input logic [WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BAUD_W-1:0]  r_baud;
    logic [BAUD_W-1:0]  w_baud_nxt;
    logic [BIT_W-1:0]   r_bit;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               r_par_en;
    logic               w_par_en_nxt;
    logic               r_par_typ;
    logic               w_par_typ_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_baud_last;

    assign w_baud_last = (r_baud == BAUD_LAST);

    // Next-state, baud/bit counters and request latching.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_nxt     = r_bit;
        w_data_nxt    = r_data;
        w_par_en_nxt  = r_par_en;
        w_par_typ_nxt = r_par_typ;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = BAUD_ZERO;
                w_bit_nxt  = BIT_ZERO;
                if (data_valid) begin
                    w_state_nxt   = S_START;
                    w_data_nxt    = p_data;
                    w_par_en_nxt  = par_en;
                    w_par_typ_nxt = par_typ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = BAUD_ZERO;
                    w_bit_nxt   = BIT_ZERO;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = BAUD_ZERO;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt   = BIT_ZERO;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (w_baud_last) begin
                    w_baud_nxt  = BAUD_ZERO;
                    w_state_nxt = S_STOP;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt  = BAUD_ZERO;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = BAUD_ZERO;
                w_bit_nxt   = BIT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes
    // on the same edge that enters each bit, keeping inputs off the output path.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        case (w_state_nxt)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
            end
            S_START: begin
                w_tx_nxt = 1'b0;
            end
            S_DATA: begin
                w_tx_nxt = w_data_nxt[w_bit_nxt];
            end
            S_PARITY: begin
                w_tx_nxt = parity_bit(w_data_nxt, w_par_typ_nxt);
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
            end
            default: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // State, counter, latched-request and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= BAUD_ZERO;
            r_bit     <= BIT_ZERO;
            r_data    <= DATA_ZERO;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit     <= w_bit_nxt;
            r_data    <= w_data_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_typ <= w_par_typ_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (WIDTH=8, CLKS_PER_BIT=4): frame shape, parity,
// ignored requests, back-to-back spacing and asynchronous reset.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_vec;
    int n_err;

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, tx_out, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic start_req(input logic [7:0] d, input logic pe, input logic pt);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
    endtask

    // Accepts at the next rising edge, then samples every cycle of the frame
    // on falling edges, ending on the first cycle after the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                               input logic exp_par, input int pulse_at,
                               input logic hold, input logic [7:0] next_d);
        logic [10:0] bits;
        int          nb;
        int          bidx;
        bits    = 11'h7FF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pe) bits[9] = exp_par;
        nb = pe ? 11 : 10;
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < nb * CPB; s++) begin
            if (s == 0) begin
                if (hold) p_data = next_d;
                else data_valid = 1'b0;
            end
            if (s == pulse_at) begin
                data_valid = 1'b1;
                p_data     = 8'hFF;
                par_en     = ~par_en;
            end else if (pulse_at >= 0 && s == pulse_at + 1) begin
                data_valid = 1'b0;
            end
            bidx = s / CPB;
            check($sformatf("%s_tx_c%0d", tag, s), tx_out, bits[bidx[3:0]]);
            check($sformatf("%s_busy_c%0d", tag, s), busy, 1'b1);
            @(negedge clk);
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        clk        = 1'b0;
        rst_n      = 1'b1;
        data_valid = 1'b0;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1 check_idle("rst_async");
        repeat (2) begin
            @(negedge clk);
            check_idle("rst_hold");
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_rst");
        end

        // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 for 40 cycles
        start_req(8'hA5, 1'b0, 1'b0);
        check_frame("nopar", 8'hA5, 1'b0, 1'b0, -1, 1'b0, 8'h00);

        // 0xA5 has four ones: even parity 0, odd parity 1, 44 cycles each
        start_req(8'hA5, 1'b1, 1'b0);
        check_frame("even", 8'hA5, 1'b1, 1'b0, -1, 1'b0, 8'h00);
        start_req(8'hA5, 1'b1, 1'b1);
        check_frame("odd", 8'hA5, 1'b1, 1'b1, -1, 1'b0, 8'h00);

        // Request mid-frame is ignored; 0x3C has four ones -> even parity 0
        start_req(8'h3C, 1'b1, 1'b0);
        check_frame("busyreq", 8'h3C, 1'b1, 1'b0, 10, 1'b0, 8'h00);
        repeat (12) begin
            @(negedge clk);
            check_idle("busyreq_noframe");
        end

        // Back-to-back with data_valid held high: one idle cycle in between
        start_req(8'h00, 1'b0, 1'b0);
        check_frame("b2b0", 8'h00, 1'b0, 1'b0, -1, 1'b1, 8'hFF);
        check_frame("b2b1", 8'hFF, 1'b0, 1'b0, -1, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("b2b_after");

        // Reset during the third data bit of 0x5A (bit2 = 0)
        start_req(8'h5A, 1'b0, 1'b0);
        @(posedge clk);
        repeat (13) @(posedge clk);
        #2;
        check("mid_tx", tx_out, 1'b0);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1 check_idle("mid_rst_async");
        p_data     = 8'h5A;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("mid_rst_hold");
        end
        rst_n = 1'b0;
        rst_n = 1'b1;

        // Request present as reset releases; 0x5A has four ones -> odd parity 1
        check_frame("clean", 8'h5A, 1'b1, 1'b1, -1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
